// File: rtl/codeword_serializer.sv
// Parallel-to-serial codeword transmitter: W-bit chunks are shifted out MSB first,
// one bit per clock, with a one-chunk holding register so consecutive chunks stream without gaps.
module codeword_serializer #(
    parameter int N  = 2048,
    parameter int M  = 32,
    parameter int La = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [M*La-1:0] in_data_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            tx_en_i,
    input  logic            flush_i,
    output logic            ser_out_o,
    output logic            ser_valid_o,
    output logic            sof_o,
    output logic            eof_o,
    output logic            busy_o
);

    localparam int W      = M * La;
    localparam int CHUNKS = N / W;
    localparam int BW     = (W > 1) ? $clog2(W) : 1;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [BW-1:0] BIT_LAST   = BW'(W - 1);
    localparam logic [CW-1:0] CHUNK_LAST = CW'(CHUNKS - 1);

    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          sh_full_q, sh_full_d;
    logic          hold_full_q, hold_full_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] chunk_cnt_q, chunk_cnt_d;

    logic shift_en, last_bit, accept, to_shifter, to_hold;

    assign shift_en   = tx_en_i & sh_full_q;
    assign last_bit   = shift_en & (bit_cnt_q == BIT_LAST);
    assign accept     = in_valid_i & ~hold_full_q;
    // A chunk bypasses the hold register when the shifter is free now or frees up this edge.
    assign to_shifter = accept & (~sh_full_q | last_bit);
    assign to_hold    = accept & ~to_shifter;

    always_comb begin
        sh_d        = sh_q;
        hold_d      = hold_q;
        sh_full_d   = sh_full_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        chunk_cnt_d = chunk_cnt_q;
        if (flush_i) begin
            sh_d        = '0;
            hold_d      = '0;
            sh_full_d   = 1'b0;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
            chunk_cnt_d = '0;
        end else begin
            if (shift_en) begin
                if (last_bit) begin
                    bit_cnt_d   = '0;
                    chunk_cnt_d = (chunk_cnt_q == CHUNK_LAST) ? '0 : chunk_cnt_q + CW'(1);
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                    end else if (to_shifter) begin
                        sh_d = in_data_i;
                    end else begin
                        sh_full_d = 1'b0;
                    end
                end else begin
                    sh_d      = {sh_q[W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            if (to_shifter && !sh_full_q) begin
                sh_d      = in_data_i;
                sh_full_d = 1'b1;
            end
            if (to_hold) begin
                hold_d      = in_data_i;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q        <= '0;
            hold_q      <= '0;
            sh_full_q   <= 1'b0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            chunk_cnt_q <= '0;
        end else begin
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            sh_full_q   <= sh_full_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            chunk_cnt_q <= chunk_cnt_d;
        end
    end

    assign in_ready_o  = ~hold_full_q;
    assign ser_valid_o = shift_en;
    assign ser_out_o   = shift_en & sh_q[W-1];
    assign sof_o       = shift_en & (bit_cnt_q == '0) & (chunk_cnt_q == '0);
    assign eof_o       = shift_en & (bit_cnt_q == BIT_LAST) & (chunk_cnt_q == CHUNK_LAST);
    assign busy_o      = sh_full_q | hold_full_q;

endmodule

// File: tb/tb_codeword_serializer.sv
// Self-checking bench for codeword_serializer (W=8, CHUNKS=4): the output stream is recorded
// per cycle and compared against the accepted chunks and the frame position of each valid bit.
module tb_codeword_serializer;

    localparam int N  = 32;
    localparam int M  = 2;
    localparam int La = 4;
    localparam int W  = M * La;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         tx_en = 1'b1;
    logic         flush = 1'b0;
    logic         ser_out, ser_valid, sof, eof, busy;

    always #5 clk = ~clk;

    codeword_serializer #(.N(N), .M(M), .La(La)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .tx_en_i(tx_en), .flush_i(flush), .ser_out_o(ser_out),
        .ser_valid_o(ser_valid), .sof_o(sof), .eof_o(eof), .busy_o(busy)
    );

    typedef struct packed {
        logic v, d, s, e, rdy, bsy, txen;
    } ent_t;

    ent_t trace[$];
    bit   rec_en = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always @(negedge clk)
        if (rec_en) trace.push_back({ser_valid, ser_out, sof, eof, in_ready, busy, tx_en});

    task automatic start_rec();
        trace.delete();
        rec_en = 1'b1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Present one chunk and return at #1 after the edge that accepted it.
    task automatic send(input logic [W-1:0] d);
        bit r, ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) $display("FAIL accept_timeout chunk %0h not accepted within 100 cycles", d);
        else passes++;
    endtask

    task automatic test_reset();
        logic [W-1:0] d = 8'h3C;
        #1;
        checks++; if ({in_ready, ser_valid, ser_out, sof, eof, busy} !== 6'b100000)
            $display("FAIL reset_outputs got %b exp 100000", {in_ready, ser_valid, ser_out, sof, eof, busy});
        else passes++;
        @(posedge clk); #1; rst_n = 1'b1;
        send(8'hB7);
        repeat (3) @(posedge clk);
        #3;
        checks++; if (ser_valid !== 1'b1) $display("FAIL reset_preshift ser_valid got %b exp 1", ser_valid);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, ser_valid, ser_out, sof, eof, busy} !== 6'b100000)
            $display("FAIL reset_async got %b exp 100000", {in_ready, ser_valid, ser_out, sof, eof, busy});
        else passes++;
        @(posedge clk); #1; rst_n = 1'b1;
        start_rec();
        send(d);
        repeat (9) @(posedge clk); #1;
        rec_en = 1'b0;
        checks++; if (trace.size() < 10) begin
            $display("FAIL reset_len got %0d entries exp >=10", trace.size()); return;
        end else passes++;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if ({trace[i].v, trace[i].d, trace[i].s} !== {1'b1, d[W-i], (i == 1)})
                $display("FAIL reset_resume cyc %0d got v/d/sof %b exp %b", i,
                         {trace[i].v, trace[i].d, trace[i].s}, {1'b1, d[W-i], (i == 1)});
            else passes++;
        end
    endtask

    task automatic test_single();
        logic [W-1:0] d = 8'hA5;
        do_flush();
        start_rec();
        send(d);
        repeat (9) @(posedge clk); #1;
        rec_en = 1'b0;
        checks++; if (trace.size() < 10) begin
            $display("FAIL single_len got %0d entries exp >=10", trace.size()); return;
        end else passes++;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if ({trace[i].v, trace[i].d, trace[i].s, trace[i].e} !== {1'b1, d[W-i], (i == 1), 1'b0})
                $display("FAIL single_bit cyc %0d got v/d/sof/eof %b exp %b", i,
                         {trace[i].v, trace[i].d, trace[i].s, trace[i].e}, {1'b1, d[W-i], (i == 1), 1'b0});
            else passes++;
        end
        checks++; if ({trace[9].v, trace[9].d} !== 2'b00)
            $display("FAIL single_end got v/d %b exp 00", {trace[9].v, trace[9].d});
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ch [4] = '{8'hFF, 8'h00, 8'hF0, 8'h0F};
        logic [W-1:0] c;
        do_flush();
        start_rec();
        for (int k = 0; k < 4; k++) send(ch[k]);
        repeat (20) @(posedge clk); #1;
        rec_en = 1'b0;
        checks++; if (trace.size() < 34) begin
            $display("FAIL b2b_len got %0d entries exp >=34", trace.size()); return;
        end else passes++;
        for (int i = 1; i <= 32; i++) begin
            c = ch[(i-1)/W];
            checks++;
            if ({trace[i].v, trace[i].d, trace[i].s, trace[i].e} !== {1'b1, c[W-1-((i-1)%W)], (i == 1), (i == 32)})
                $display("FAIL b2b_bit cyc %0d got v/d/sof/eof %b exp %b", i,
                         {trace[i].v, trace[i].d, trace[i].s, trace[i].e},
                         {1'b1, c[W-1-((i-1)%W)], (i == 1), (i == 32)});
            else passes++;
        end
        checks++; if (trace[33].v !== 1'b0) $display("FAIL b2b_end ser_valid got %b exp 0", trace[33].v);
        else passes++;
        checks++; if ({trace[2].rdy, trace[2].bsy} !== 2'b01)
            $display("FAIL b2b_hold_ready got rdy/busy %b exp 01", {trace[2].rdy, trace[2].bsy});
        else passes++;
    endtask

    task automatic test_tx_pause();
        logic [W-1:0] d = 8'hC3;
        bit expv;
        int b;
        do_flush();
        start_rec();
        send(d);
        repeat (4) @(posedge clk); #1;
        tx_en = 1'b0;
        repeat (3) @(posedge clk); #1;
        tx_en = 1'b1;
        repeat (5) @(posedge clk); #1;
        rec_en = 1'b0;
        checks++; if (trace.size() < 13) begin
            $display("FAIL pause_len got %0d entries exp >=13", trace.size()); return;
        end else passes++;
        for (int i = 1; i <= 12; i++) begin
            expv = (i <= 4) || (i >= 8 && i <= 11);
            b    = (i <= 4) ? i - 1 : i - 4;
            checks++;
            if ({trace[i].v, trace[i].d, trace[i].s} !== {expv, expv & d[W-1-b], expv & (i == 1)})
                $display("FAIL pause_bit cyc %0d got v/d/sof %b exp %b", i,
                         {trace[i].v, trace[i].d, trace[i].s}, {expv, expv & d[W-1-b], expv & (i == 1)});
            else passes++;
        end
        checks++; if (trace[6].bsy !== 1'b1) $display("FAIL pause_busy got %b exp 1", trace[6].bsy);
        else passes++;
    endtask

    task automatic test_underflow();
        logic         exp_q[$];
        logic [W-1:0] c;
        int           k = 0;
        do_flush();
        start_rec();
        for (int n = 0; n < 4; n++) begin
            c = W'($urandom);
            for (int j = W - 1; j >= 0; j--) exp_q.push_back(c[j]);
            send(c);
            if (n == 1) begin repeat (20) @(posedge clk); #1; end
        end
        repeat (20) @(posedge clk); #1;
        rec_en = 1'b0;
        checks++; if (trace.size() > 17 && trace[17].v !== 1'b0)
            $display("FAIL underflow_gap ser_valid got %b exp 0", trace[17].v);
        else passes++;
        foreach (trace[i]) begin
            checks++;
            if (trace[i].v) begin
                if (k >= exp_q.size() || {trace[i].d, trace[i].s, trace[i].e} !==
                    {exp_q[k], (k % N == 0), (k % N == N - 1)})
                    $display("FAIL underflow_bit pos %0d got d/sof/eof %b exp %b", k,
                             {trace[i].d, trace[i].s, trace[i].e}, {exp_q[k], (k % N == 0), (k % N == N - 1)});
                else passes++;
                k++;
            end else if ({trace[i].d, trace[i].s, trace[i].e} !== 3'b000)
                $display("FAIL underflow_idle cyc %0d got d/sof/eof %b exp 000", i, {trace[i].d, trace[i].s, trace[i].e});
            else passes++;
        end
        checks++; if (k != exp_q.size()) $display("FAIL underflow_count got %0d bits exp %0d", k, exp_q.size());
        else passes++;
    endtask

    task automatic test_flush();
        logic [W-1:0] ch [4];
        logic [W-1:0] c;
        for (int n = 0; n < 4; n++) ch[n] = W'($urandom);
        do_flush();
        start_rec();
        for (int n = 0; n < 3; n++) send(ch[n]);
        repeat (2) @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        send(ch[3]);
        repeat (10) @(posedge clk); #1;
        rec_en = 1'b0;
        checks++; if (trace.size() < 22) begin
            $display("FAIL flush_len got %0d entries exp >=22", trace.size()); return;
        end else passes++;
        for (int i = 1; i <= 12; i++) begin
            c = ch[(i-1)/W];
            checks++;
            if ({trace[i].v, trace[i].d} !== {1'b1, c[W-1-((i-1)%W)]})
                $display("FAIL flush_pre cyc %0d got v/d %b exp %b", i, {trace[i].v, trace[i].d}, {1'b1, c[W-1-((i-1)%W)]});
            else passes++;
        end
        checks++; if ({trace[12].rdy, trace[12].bsy} !== 2'b01)
            $display("FAIL flush_holdfull got rdy/busy %b exp 01", {trace[12].rdy, trace[12].bsy});
        else passes++;
        checks++; if ({trace[13].v, trace[13].bsy, trace[13].rdy} !== 3'b001)
            $display("FAIL flush_clear got v/busy/rdy %b exp 001", {trace[13].v, trace[13].bsy, trace[13].rdy});
        else passes++;
        for (int i = 14; i <= 21; i++) begin
            checks++;
            if ({trace[i].v, trace[i].d, trace[i].s} !== {1'b1, ch[3][W-1-(i-14)], (i == 14)})
                $display("FAIL flush_after cyc %0d got v/d/sof %b exp %b", i,
                         {trace[i].v, trace[i].d, trace[i].s}, {1'b1, ch[3][W-1-(i-14)], (i == 14)});
            else passes++;
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h81;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if ({busy, ser_valid, in_ready} !== 3'b001)
            $display("FAIL flush_priority got busy/valid/rdy %b exp 001", {busy, ser_valid, in_ready});
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic exp_q[$];
        bit   acc;
        int   k = 0;
        do_flush();
        start_rec();
        for (int cyc = 0; cyc < 600; cyc++) begin
            tx_en = ($urandom_range(3) != 0);
            if (!in_valid && $urandom_range(2) == 0) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
            end
            @(negedge clk); acc = in_valid & in_ready;
            @(posedge clk); #1;
            if (acc) begin
                for (int j = W - 1; j >= 0; j--) exp_q.push_back(in_data[j]);
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tx_en    = 1'b1;
        repeat (30) @(posedge clk); #1;
        rec_en = 1'b0;
        foreach (trace[i]) begin
            checks++;
            if (trace[i].v) begin
                if (!trace[i].txen || k >= exp_q.size() || {trace[i].d, trace[i].s, trace[i].e} !==
                    {exp_q[k], (k % N == 0), (k % N == N - 1)})
                    $display("FAIL random_bit pos %0d tx_en %b got d/sof/eof %b exp %b", k, trace[i].txen,
                             {trace[i].d, trace[i].s, trace[i].e}, {exp_q[k], (k % N == 0), (k % N == N - 1)});
                else passes++;
                k++;
            end else if ({trace[i].d, trace[i].s, trace[i].e} !== 3'b000)
                $display("FAIL random_idle cyc %0d got d/sof/eof %b exp 000", i, {trace[i].d, trace[i].s, trace[i].e});
            else passes++;
        end
        checks++; if (k != exp_q.size()) $display("FAIL random_count got %0d bits exp %0d", k, exp_q.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tx_pause();
        test_underflow();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
